// File: rtl/cs_pkg.sv
// Shared constants and FSM state encoding for the CS stream sequencer.
package cs_pkg;

    localparam int DATA_W = 8;   // core X sample width
    localparam int Y_W    = 10;  // core Y result width
    localparam int WIN    = 9;   // core window length
    localparam int LAT    = 1;   // core_en to core_y latency
    localparam int LEN_W  = 16;  // frame length counter width

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FILL  = 3'd2,
        RUN   = 3'd3,
        FLUSH = 3'd4,
        FIN   = 3'd5
    } state_e;

endpackage

// File: rtl/cs_out_fifo.sv
// Small synchronous FIFO holding core results until downstream accepts them.
module cs_out_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 10,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when a pop frees the slot this cycle.
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    // Drive zero while empty so out_data reads 0 after reset.
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // The upstream credit scheme must never push into a full, non-popping FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && full && !pop));

endmodule

// File: rtl/cs_stream_seq.sv
// Sequencer in front of the CS approximate-average core: gates sample issues,
// clears the core per frame, drops window-fill results and buffers outputs.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid never depends on ready, and data is only meaningful while
// valid is high.
module cs_stream_seq #(
    parameter int DATA_W = cs_pkg::DATA_W,
    parameter int Y_W    = cs_pkg::Y_W,
    parameter int WIN    = cs_pkg::WIN,
    parameter int LAT    = cs_pkg::LAT,
    parameter int LEN_W  = cs_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              core_en,
    output logic [DATA_W-1:0] core_x,
    output logic              core_clr,
    input  logic [Y_W-1:0]    core_y,
    output logic              out_valid,
    output logic [Y_W-1:0]    out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [2:0]        dbg_state
);

    import cs_pkg::*;

    localparam int FDEPTH = LAT + 1;
    localparam int CNT_W  = $clog2(FDEPTH + 1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  sample_cnt_q, sample_cnt_d, cnt_inc;
    logic [LAT-1:0]    infl_q, infl_d;
    logic [DATA_W-1:0] core_x_q, core_x_d;
    logic              cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]  fifo_cnt, inflight_cnt;
    logic [CNT_W:0]    credit_used;
    logic              accept, mark, fifo_push, fifo_pop, fifo_empty;

    // Results already queued or still inside the core; RUN only issues when
    // every one of them is guaranteed a FIFO slot.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < LAT; i++) inflight_cnt = inflight_cnt + CNT_W'(infl_q[i]);
        credit_used = {1'b0, fifo_cnt} + {1'b0, inflight_cnt};
    end

    // Upstream ready depends only on state and credit, never on in_valid.
    always_comb begin
        in_ready = 1'b0;
        if (state_q == FILL)     in_ready = 1'b1;
        else if (state_q == RUN) in_ready = (credit_used < (CNT_W + 1)'(FDEPTH));
    end

    assign accept    = in_valid && in_ready;
    assign core_en   = accept;
    // core_x follows the accepted sample in the same cycle and holds otherwise.
    assign core_x    = accept ? in_data : core_x_q;
    assign core_x_d  = core_x;
    assign cnt_inc   = sample_cnt_q + LEN_W'(1);
    assign mark      = accept && (state_q == RUN);
    // Shift the output marks toward the tail; the tail lines up with core_y.
    assign infl_d    = LAT'({infl_q, mark});
    assign fifo_push = infl_q[LAT-1];
    assign fifo_pop  = out_valid && out_ready;
    assign out_valid = !fifo_empty;
    assign core_clr  = (state_q == CLR);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign cfg_err   = cfg_err_q;
    assign dbg_state = state_q;

    // Frame FSM next-state, length latch and sample counting.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        sample_cnt_d = sample_cnt_q;
        cfg_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_len < LEN_W'(WIN)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        len_d        = frame_len;
                        sample_cnt_d = '0;
                        state_d      = CLR;
                    end
                end
            end
            CLR: state_d = FILL;
            FILL: begin
                if (accept) begin
                    sample_cnt_d = cnt_inc;
                    if (cnt_inc == LEN_W'(WIN - 1)) state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    sample_cnt_d = cnt_inc;
                    if (cnt_inc == len_q) state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Leave as the last result is popped so done follows it directly.
                if (infl_q == '0 &&
                    (fifo_cnt == '0 || (fifo_cnt == CNT_W'(1) && fifo_pop)))
                    state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            sample_cnt_q <= '0;
            infl_q       <= '0;
            core_x_q     <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            sample_cnt_q <= sample_cnt_d;
            infl_q       <= infl_d;
            core_x_q     <= core_x_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    cs_out_fifo #(
        .DEPTH (FDEPTH),
        .W     (Y_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (core_y),
        .pop   (fifo_pop),
        .rdata (out_data),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

endmodule
